cpr_pack_fifo: RTL and testbench

- Parametrised successor of the eight-lane compressor front end.
- Takes NUM_DATA words per beat, each with a 2-bit compression tag, and drops or trims each word according to its tag.
- Packs the surviving half-words contiguously from the LSB, computes the packed length, and buffers {tags, payload, length} in an internal FIFO.
- Valid/ready handshakes on both sides; input backpressure is credit-based.

---
 rtl/cpr_pkg.sv | 30 +++
 rtl/cpr_sync_fifo.sv | 61 ++++++
 rtl/cpr_pack_fifo.sv | 207 ++++++++++++++++++++
 tb/tb_cpr_pack_fifo.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpr_pkg.sv
// Shared tag encoding and arithmetic helpers for the compressor pack FIFO.
package cpr_pkg;

    localparam int TAG_WIDTH = 2;

    typedef logic [TAG_WIDTH-1:0] tag_t;

    localparam tag_t TAG_ZERO = 2'b00;
    localparam tag_t TAG_REF  = 2'b01;
    localparam tag_t TAG_HALF = 2'b10;
    localparam tag_t TAG_FULL = 2'b11;

    // Number of half-words a lane contributes to the packed payload.
    function automatic logic [1:0] hw_count(input tag_t tag);
        logic [1:0] n;
        case (tag)
            TAG_HALF: n = 2'd1;
            TAG_FULL: n = 2'd2;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/cpr_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
// The head word reads as zero while the FIFO is empty.
module cpr_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_valid,
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_wr_en & ~w_full;
    assign w_pop   = i_rd_en & ~w_empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid   = ~w_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/cpr_pack_fifo.sv
// Tag-checked half-word packer with a two-stage pipeline feeding a credit-protected FIFO.
// Define CPR_STATS_EN to add the stat_in_hw / stat_out_hw saturating counters.
module cpr_pack_fifo
    import cpr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DATA   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_bypass,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*NUM_DATA-1:0]   data_in,
    input  logic [DATA_WIDTH*NUM_DATA-1:0]   ref_in,
    input  logic [TAG_WIDTH*NUM_DATA-1:0]    tag_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [TAG_WIDTH*NUM_DATA-1:0]    out_tag,
    output logic [DATA_WIDTH*NUM_DATA-1:0]   out_data,
    output logic [LEN_WIDTH-1:0]             out_len,
    output logic [ADDR_WIDTH:0]              fifo_count,
    output logic                             mismatch_err
`ifdef CPR_STATS_EN
    ,
    output logic [31:0]                      stat_in_hw,
    output logic [31:0]                      stat_out_hw
`endif
);

    localparam int HW     = DATA_WIDTH / 2;
    localparam int PAY_W  = DATA_WIDTH * NUM_DATA;
    localparam int TAGS_W = TAG_WIDTH * NUM_DATA;
    localparam int OFF_W  = $clog2(2*NUM_DATA + 1);
    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int CW     = ADDR_WIDTH + 2;

    typedef struct packed {
        logic [TAGS_W-1:0]    tag;
        logic [PAY_W-1:0]     data;
        logic [LEN_WIDTH-1:0] len;
    } entry_t;

    // Stage 0: tag check, half-word counts and exclusive prefix offsets.
    tag_t             w_eff_tag [NUM_DATA];
    logic [1:0]       w_cnt     [NUM_DATA];
    logic [OFF_W-1:0] w_off     [NUM_DATA];
    logic             w_promote;
    logic             w_accept;

    always_comb begin
        logic [DATA_WIDTH-1:0] w_lane_word;
        logic [DATA_WIDTH-1:0] w_lane_ref;
        tag_t                  w_lane_tag;
        logic                  w_lane_bad;
        logic [OFF_W-1:0]      w_run;
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        w_promote = 1'b0;
        w_run     = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
            w_lane_word = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            w_lane_ref  = ref_in[i*DATA_WIDTH +: DATA_WIDTH];
            w_lane_tag  = tag_in[i*TAG_WIDTH +: TAG_WIDTH];
            case (w_lane_tag)
                TAG_ZERO: w_lane_bad = (w_lane_word != '0);
                TAG_REF:  w_lane_bad = (w_lane_word != w_lane_ref);
                TAG_HALF: w_lane_bad = (w_lane_word[DATA_WIDTH-1:HW] != '0);
                default:  w_lane_bad = 1'b0;
            endcase
            if (cfg_bypass) begin
                w_eff_tag[i] = TAG_FULL;
            end else if (w_lane_bad) begin
                w_eff_tag[i] = TAG_FULL;
                w_promote    = 1'b1;
            end else begin
                w_eff_tag[i] = w_lane_tag;
            end
            w_cnt[i] = hw_count(w_eff_tag[i]);
            w_off[i] = w_run;
            w_run    = w_run + OFF_W'(w_cnt[i]);
        end
    end

    assign w_accept = in_valid & in_ready;

    // Stage 1 registers.
    logic             r_s1_valid;
    tag_t             r_s1_tag  [NUM_DATA];
    logic [1:0]       r_s1_cnt  [NUM_DATA];
    logic [OFF_W-1:0] r_s1_off  [NUM_DATA];
    logic [PAY_W-1:0] r_s1_data;
    logic             r_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept && w_promote) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_data <= data_in;
            for (int i = 0; i < NUM_DATA; i++) begin
                r_s1_tag[i] <= w_eff_tag[i];
                r_s1_cnt[i] <= w_cnt[i];
                r_s1_off[i] <= w_off[i];
            end
        end
    end

    // Lanes land on disjoint half-word ranges, so OR-ing shifted lanes packs them in order.
    logic [PAY_W-1:0]     w_packed;
    logic [LEN_WIDTH-1:0] w_len;

    always_comb begin
        logic [DATA_WIDTH-1:0] w_src_word;
        logic [PAY_W-1:0]      w_lane;
        w_packed = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
            w_src_word = r_s1_data[i*DATA_WIDTH +: DATA_WIDTH];
            case (r_s1_cnt[i])
                2'd2:    w_lane = PAY_W'(w_src_word);
                2'd1:    w_lane = PAY_W'(w_src_word[HW-1:0]);
                default: w_lane = '0;
            endcase
            w_packed = w_packed | (w_lane << (int'(r_s1_off[i]) * HW));
        end
    end

    assign w_len = LEN_WIDTH'(r_s1_off[NUM_DATA-1]) + LEN_WIDTH'(r_s1_cnt[NUM_DATA-1]);

    // Stage 2 registers; the FIFO write happens on the edge that retires this stage.
    logic                 r_s2_valid;
    logic [TAGS_W-1:0]    r_s2_tag;
    logic [PAY_W-1:0]     r_s2_data;
    logic [LEN_WIDTH-1:0] r_s2_len;

    always_ff @(posedge clk) begin
        if (!reset) r_s2_valid <= 1'b0;
        else        r_s2_valid <= r_s1_valid;
    end

    always_ff @(posedge clk) begin
        if (r_s1_valid) begin
            r_s2_data <= w_packed;
            r_s2_len  <= w_len;
            for (int i = 0; i < NUM_DATA; i++) begin
                r_s2_tag[i*TAG_WIDTH +: TAG_WIDTH] <= r_s1_tag[i];
            end
        end
    end

    entry_t w_wr_entry;
    entry_t w_rd_entry;

    assign w_wr_entry = '{tag: r_s2_tag, data: r_s2_data, len: r_s2_len};

    cpr_sync_fifo #(
        .DATA_WIDTH ($bits(entry_t)),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .i_rst_n   (reset),
        .i_wr_en   (r_s2_valid),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (out_ready),
        .o_rd_data (w_rd_entry),
        .o_valid   (out_valid),
        .o_count   (fifo_count)
    );

    assign out_tag      = w_rd_entry.tag;
    assign out_data     = w_rd_entry.data;
    assign out_len      = w_rd_entry.len;
    assign mismatch_err = r_err;

    // Every beat in the pipeline holds a reserved FIFO slot, so the pipeline never has to stall.
    logic [CW-1:0] w_credit_used;

    assign w_credit_used = {1'b0, fifo_count} + CW'(r_s1_valid) + CW'(r_s2_valid);
    assign in_ready      = reset & (w_credit_used < CW'(DEPTH));

`ifdef CPR_STATS_EN
    logic [31:0] r_stat_in_hw;
    logic [31:0] r_stat_out_hw;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_in_hw  <= '0;
            r_stat_out_hw <= '0;
        end else begin
            if (w_accept)   r_stat_in_hw  <= sat_add32(r_stat_in_hw, 32'(2*NUM_DATA));
            if (r_s2_valid) r_stat_out_hw <= sat_add32(r_stat_out_hw, 32'(r_s2_len));
        end
    end

    assign stat_in_hw  = r_stat_in_hw;
    assign stat_out_hw = r_stat_out_hw;
`endif

endmodule

// File: tb/tb_cpr_pack_fifo.sv
// Scoreboard bench for cpr_pack_fifo: directed beats push expected entries, a monitor pops and compares.
// A second, deeper instance is used only for the mid-operation reset scenario.
module tb_cpr_pack_fifo;

    localparam logic [255:0] REF_VEC =
        256'hC0DE0007_C0DE0006_C0DE0005_C0DE0004_C0DE0003_C0DE0002_C0DE0001_C0DE0000;

    typedef struct {
        logic [15:0]  tag;
        logic [255:0] data;
        logic [7:0]   len;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         cfg_bypass;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] data_in;
    logic [255:0] ref_in;
    logic [15:0]  tag_in;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_tag;
    logic [255:0] out_data;
    logic [7:0]   out_len;
    logic [2:0]   fifo_count;
    logic         mismatch_err;

    logic         d_in_valid;
    logic         d_in_ready;
    logic         d_out_valid;
    logic         d_out_ready;
    logic [15:0]  d_out_tag;
    logic [255:0] d_out_data;
    logic [7:0]   d_out_len;
    logic [3:0]   d_fifo_count;
    logic         d_mismatch_err;

`ifdef CPR_STATS_EN
    logic [31:0] stat_in_hw, stat_out_hw, d_stat_in_hw, d_stat_out_hw;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   max_cnt = 0;
    exp_t exp_q[$];

    cpr_pack_fifo #(.DATA_WIDTH(32), .NUM_DATA(8), .ADDR_WIDTH(2), .LEN_WIDTH(8)) u_dut (
`ifdef CPR_STATS_EN
        .stat_in_hw   (stat_in_hw),
        .stat_out_hw  (stat_out_hw),
`endif
        .clk          (clk),
        .reset        (reset),
        .cfg_bypass   (cfg_bypass),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .ref_in       (ref_in),
        .tag_in       (tag_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_tag      (out_tag),
        .out_data     (out_data),
        .out_len      (out_len),
        .fifo_count   (fifo_count),
        .mismatch_err (mismatch_err)
    );

    cpr_pack_fifo #(.DATA_WIDTH(32), .NUM_DATA(8), .ADDR_WIDTH(3), .LEN_WIDTH(8)) u_dut_deep (
`ifdef CPR_STATS_EN
        .stat_in_hw   (d_stat_in_hw),
        .stat_out_hw  (d_stat_out_hw),
`endif
        .clk          (clk),
        .reset        (reset),
        .cfg_bypass   (cfg_bypass),
        .in_valid     (d_in_valid),
        .in_ready     (d_in_ready),
        .data_in      (data_in),
        .ref_in       (ref_in),
        .tag_in       (tag_in),
        .out_valid    (d_out_valid),
        .out_ready    (d_out_ready),
        .out_tag      (d_out_tag),
        .out_data     (d_out_data),
        .out_len      (d_out_len),
        .fifo_count   (d_fifo_count),
        .mismatch_err (d_mismatch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every lane tagged full: the expected payload is the input vector itself.
    function automatic logic [255:0] full_vec(input int k);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = {8'(k), 8'(i), 16'hA55A};
        return v;
    endfunction

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got data %0h with nothing expected", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_tag", 256'(out_tag), 256'(e.tag));
                check("out_data", out_data, e.data);
                check("out_len", 256'(out_len), 256'(e.len));
            end
        end
    end

    // Called right after a rising edge; returns right after the accepting edge.
    task automatic send(input logic [15:0] tg, input logic [255:0] d, input logic byp,
                        input logic [15:0] etag, input logic [255:0] edata, input logic [7:0] elen);
        bit done;
        done       = 1'b0;
        tag_in     = tg;
        data_in    = d;
        ref_in     = REF_VEC;
        cfg_bypass = byp;
        in_valid   = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{etag, edata, elen});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("send_accept_timeout", 256'(done), 256'(1));
        in_valid   = 1'b0;
        cfg_bypass = 1'b0;
    endtask

    task automatic stream(input int cycles, input int max_beats, input int base, output int accepted);
        accepted   = 0;
        tag_in     = 16'hFFFF;
        ref_in     = REF_VEC;
        cfg_bypass = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            in_valid = (accepted < max_beats);
            data_in  = full_vec(base + accepted);
            @(negedge clk);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (in_valid && in_ready) begin
                exp_q.push_back('{16'hFFFF, full_vec(base + accepted), 8'd16});
                accepted++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        check(name, 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int lat;
        bit seen;

        reset       = 1'b0;
        cfg_bypass  = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        d_in_valid  = 1'b0;
        d_out_ready = 1'b0;
        data_in     = '0;
        ref_in      = REF_VEC;
        tag_in      = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_fifo_count", 256'(fifo_count), 256'(0));
        check("rst_out_data", out_data, 256'(0));
        check("rst_out_tag_len", 256'({out_tag, out_len}), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(0));
        check("rst_mismatch", 256'(mismatch_err), 256'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("release_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1;

        // All lanes full, plus acceptance-to-valid latency.
        send(16'hFFFF, 256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000, 1'b0,
             16'hFFFF, 256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000, 8'd16);
        lat  = 0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        check("latency", 256'(lat), 256'(3));
        drain("drain_full");

        // Mixed tags, then the same beat in bypass.
        send(16'h5572, 256'hC0DE0007_C0DE0006_C0DE0005_C0DE0004_C0DE0003_12345678_00000000_0000ABCD, 1'b0,
             16'h5572, 256'h1234_5678_ABCD, 8'd3);
        send(16'h5572, 256'hC0DE0007_C0DE0006_C0DE0005_C0DE0004_C0DE0003_12345678_00000000_0000ABCD, 1'b1,
             16'hFFFF, 256'hC0DE0007_C0DE0006_C0DE0005_C0DE0004_C0DE0003_12345678_00000000_0000ABCD, 8'd16);
        drain("drain_mixed");
        check("mixed_no_mismatch", 256'(mismatch_err), 256'(0));

        // Lane 3 tagged zero with nonzero data: ignored under bypass, promoted otherwise.
        send(16'hAA00, 256'h00001007_00001006_00001005_00001004_00000005_00000000_00000000_00000000, 1'b1,
             16'hFFFF, 256'h00001007_00001006_00001005_00001004_00000005_00000000_00000000_00000000, 8'd16);
        drain("drain_bypass_bad");
        check("bypass_skips_check", 256'(mismatch_err), 256'(0));
        send(16'hAA00, 256'h00001007_00001006_00001005_00001004_00000005_00000000_00000000_00000000, 1'b0,
             16'hAAC0, 256'h1007_1006_1005_1004_0000_0005, 8'd6);
        drain("drain_promote");
        check("mismatch_set", 256'(mismatch_err), 256'(1));
        send(16'hFFFF, full_vec(7), 1'b0, 16'hFFFF, full_vec(7), 8'd16);
        drain("drain_sticky");
        check("mismatch_sticky", 256'(mismatch_err), 256'(1));

        // Backpressure with a 4-entry FIFO.
        out_ready = 1'b0;
        stream(12, 10, 0, acc);
        check("bp_accepted", 256'(acc), 256'(4));
        @(negedge clk);
        check("bp_in_ready", 256'(in_ready), 256'(0));
        check("bp_fifo_count", 256'(fifo_count), 256'(4));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        stream(8, 10, 4, acc);
        check("bp_one_more", 256'(acc), 256'(1));
        @(negedge clk);
        check("bp_refull", 256'(fifo_count), 256'(4));
        @(posedge clk); #1;
        drain("drain_bp");

        // Continuous traffic.
        out_ready = 1'b1;
        max_cnt   = 0;
        stream(20, 20, 10, acc);
        check("thru_accepted", 256'(acc), 256'(20));
        check("thru_max_count_le3", 256'(max_cnt <= 3), 256'(1));
        drain("drain_thru");
        check("thru_empty", 256'(fifo_count), 256'(0));

        // Mid-operation reset on the 8-entry instance: 3 buffered, 2 in flight.
        tag_in = 16'hFFFF;
        acc    = 0;
        for (int k = 0; k < 5; k++) begin
            data_in    = full_vec(100 + k);
            d_in_valid = 1'b1;
            @(negedge clk);
            if (d_in_ready) acc++;
            @(posedge clk); #1;
        end
        d_in_valid = 1'b0;
        check("deep_accepted", 256'(acc), 256'(5));
        @(negedge clk);
        check("deep_buffered", 256'(d_fifo_count), 256'(3));
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_count", 256'(d_fifo_count), 256'(0));
        check("midrst_valid", 256'({d_out_valid, out_valid}), 256'(0));
        check("midrst_in_ready", 256'(d_in_ready), 256'(0));
        check("midrst_mismatch", 256'(mismatch_err), 256'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        d_out_ready = 1'b1;
        data_in     = full_vec(200);
        d_in_valid  = 1'b1;
        @(negedge clk);
        check("midrst_first_accept", 256'(d_in_ready), 256'(1));
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (d_out_valid) seen = 1'b1;
        end
        check("midrst_first_valid", 256'(seen), 256'(1));
        check("midrst_first_data", d_out_data, full_vec(200));
        check("midrst_first_len", 256'(d_out_len), 256'(16));
        @(posedge clk); #1;
        d_out_ready = 1'b0;

        // Ref mismatch and a half tag with nonzero upper bits, after reset cleared the error.
        send(16'h5556, 256'hC0DE0007_DEADBEEF_C0DE0005_C0DE0004_C0DE0003_C0DE0002_C0DE0001_00010002, 1'b0,
             16'h7557, 256'hDEAD_BEEF_0001_0002, 8'd4);
        drain("drain_ref_bad");
        check("ref_mismatch_set", 256'(mismatch_err), 256'(1));
        check("final_empty", 256'(fifo_count), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
